mem_bridge: RTL and testbench

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge_pkg.sv | 42 ++++
 rtl/mem_bridge_sync2.sv | 27 ++
 rtl/mem_bridge.sv | 184 ++++++++++++++++++
 tb/tb_mem_bridge.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the memory-stage bridge: FSM states, address
// decode classes, MMIO register offsets and the error read pattern.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAM_RD,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_MMIO,
    DEC_ERR
  } dec_e;

  localparam logic [3:0]  OFF_LED    = 4'h0;
  localparam logic [3:0]  OFF_SW     = 4'h4;
  localparam logic [3:0]  OFF_CYCLES = 4'h8;
  localparam logic [3:0]  OFF_ERRCNT = 4'hC;

  localparam logic [31:0] DEAD_BEEF  = 32'hDEAD_BEEF;
  localparam int          ERRCNT_W   = 16;

  // Only the LED byte of the write data is ever consumed after acceptance.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata_lo;
  } req_t;

  // Misalignment is checked first so a misaligned RAM or MMIO address is an error.
  function automatic dec_e decode(input logic [31:0] addr,
                                  input int unsigned ram_aw,
                                  input logic [31:0] mmio_base);
    if (addr[1:0] != 2'b00) return DEC_ERR;
    if ((addr >> (ram_aw + 2)) == 32'd0) return DEC_RAM;
    if (addr[31:4] == mmio_base[31:4]) return DEC_MMIO;
    return DEC_ERR;
  endfunction

endpackage

// File: rtl/mem_bridge_sync2.sv
// Two-flop synchronizer bringing an asynchronous bus into the clk domain.
module sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the two stages as distinct flops.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_bridge.sv
// Bridges a CPU memory-stage request to a synchronous RAM or to a small MMIO
// register window (LED, SW, CYCLES, ERRCNT) with a valid/ready response.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int          RAM_AW    = 6,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wren,
  output logic [31:0]       ram_data,
  input  logic [31:0]       ram_q,
  input  logic [7:0]        sw,
  output logic [7:0]        led
);

  state_e              state_q;
  logic                ready_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [31:0]         resp_rdata_q;
  req_t                req_q;
  logic                commit_q;

  logic [7:0]          led_q;
  logic [31:0]         cycles_q;
  logic [ERRCNT_W-1:0] errcnt_q;
  logic [ERRCNT_W-1:0] errcnt_d;

  logic [7:0]          sw_sync;
  logic                accept;
  dec_e                dec_in;
  dec_e                dec_commit;
  logic [31:0]         mmio_rdata;
  logic                err_inc;
  logic                err_clr;

  sync2 #(.W(8)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sw),
    .q_o   (sw_sync)
  );

  // Gating with reset keeps req_ready low for the whole reset window.
  assign req_ready = ready_q & reset;
  assign accept    = req_valid & req_ready;
  assign dec_in    = decode(req_addr, RAM_AW, MMIO_BASE);

  // The RAM sees the address in the acceptance cycle so ram_q is ready in RAM_RD.
  always_comb begin
    // NOTE: default every output first so no path leaves one unassigned (no latch).
    ram_addr = '0;
    ram_wren = 1'b0;
    ram_data = '0;
    if (accept && dec_in == DEC_RAM) begin
      ram_addr = req_addr[RAM_AW+1:2];
      ram_wren = req_we;
      ram_data = req_we ? req_wdata : 32'd0;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    unique case (req_addr[3:0])
      OFF_LED:    mmio_rdata = {24'd0, led_q};
      OFF_SW:     mmio_rdata = {24'd0, sw_sync};
      OFF_CYCLES: mmio_rdata = cycles_q;
      OFF_ERRCNT: mmio_rdata = {{(32-ERRCNT_W){1'b0}}, errcnt_q};
      default:    mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      req_q        <= '0;
      commit_q     <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q  <= 1'b0;
            commit_q <= 1'b1;
            req_q    <= '{we: req_we, addr: req_addr, wdata_lo: req_wdata[7:0]};
            unique case (dec_in)
              DEC_RAM: begin
                if (req_we) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= '0;
                end else begin
                  state_q <= S_RAM_RD;
                end
              end
              DEC_MMIO: begin
                state_q      <= S_RESP;
                resp_valid_q <= 1'b1;
                resp_err_q   <= 1'b0;
                resp_rdata_q <= req_we ? 32'd0 : mmio_rdata;
              end
              default: begin
                state_q      <= S_RESP;
                resp_valid_q <= 1'b1;
                resp_err_q   <= 1'b1;
                resp_rdata_q <= req_we ? 32'd0 : DEAD_BEEF;
              end
            endcase
          end
        end
        S_RAM_RD: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= req_q.we ? 32'd0 : ram_q;
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Register side effects commit in the cycle after acceptance from the latched
  // request; the earliest following request is accepted after they land.
  assign dec_commit = decode(req_q.addr, RAM_AW, MMIO_BASE);
  assign err_inc    = commit_q && dec_commit == DEC_ERR;
  assign err_clr    = commit_q && dec_commit == DEC_MMIO && req_q.we &&
                      req_q.addr[3:0] == OFF_ERRCNT;

  // A clearing write takes priority over a same-cycle increment.
  always_comb begin
    errcnt_d = errcnt_q;
    if (err_inc && errcnt_q != {ERRCNT_W{1'b1}}) errcnt_d = errcnt_q + 1'b1;
    if (err_clr) errcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q    <= '0;
      cycles_q <= '0;
      errcnt_q <= '0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      errcnt_q <= errcnt_d;
      if (commit_q && dec_commit == DEC_MMIO && req_q.we &&
          req_q.addr[3:0] == OFF_LED) begin
        led_q <= req_q.wdata_lo;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign led        = led_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed and randomized checks of mem_bridge against a transaction-level
// model of the address map, register file and response timing.
module tb_mem_bridge;

  localparam int          RAM_AW    = 6;
  localparam int          RAM_WORDS = 1 << RAM_AW;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_wren;
  logic [31:0]       ram_data;
  logic [31:0]       ram_q;
  logic [7:0]        sw;
  logic [7:0]        led;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bridge #(.RAM_AW(RAM_AW), .MMIO_BASE(MMIO_BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_addr   (ram_addr),
    .ram_wren   (ram_wren),
    .ram_data   (ram_data),
    .ram_q      (ram_q),
    .sw         (sw),
    .led        (led)
  );

  // Synchronous RAM the bridge talks to, plus write-strobe bookkeeping.
  logic [31:0]       ram_mem [RAM_WORDS];
  int                wren_cnt = 0;
  logic [RAM_AW-1:0] last_wr_addr = '0;
  logic [31:0]       tb_cyc = 0;

  initial for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] = 32'd0;

  always @(posedge clk) begin
    if (ram_wren) begin
      ram_mem[ram_addr] <= ram_data;
      wren_cnt          <= wren_cnt + 1;
      last_wr_addr      <= ram_addr;
    end
    ram_q <= ram_mem[ram_addr];
  end

  // Cycles elapsed since the last reset release, as a CYCLES read should see.
  always @(posedge clk) tb_cyc <= reset ? tb_cyc + 32'd1 : 32'd0;

  // Reference model state.
  logic [31:0] mem_m [RAM_WORDS];
  logic [7:0]  led_m = 8'd0;
  int          errcnt_m = 0;
  logic [7:0]  sw_m = 8'd0;

  initial for (int i = 0; i < RAM_WORDS; i++) mem_m[i] = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void predict(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] cyc,
                                  output logic [31:0] rd, output logic err,
                                  output int lat, output int nwr);
    longint unsigned a;
    bit aligned, in_ram, in_mmio;
    a       = addr;
    aligned = (a % 4) == 0;
    in_ram  = a < (64'd1 << (RAM_AW + 2));
    in_mmio = a >= MMIO_BASE && a < MMIO_BASE + 64'd16;
    rd = 32'd0; err = 1'b0; lat = 1; nwr = 0;
    if (!aligned || !(in_ram || in_mmio)) begin
      err = 1'b1;
      rd  = we ? 32'd0 : 32'hDEAD_BEEF;
      if (errcnt_m < 65535) errcnt_m++;
    end else if (in_ram) begin
      if (we) begin
        mem_m[a / 4] = wdata;
        nwr = 1;
      end else begin
        rd  = mem_m[a / 4];
        lat = 2;
      end
    end else begin
      case (a - MMIO_BASE)
        0:  if (we) led_m = wdata[7:0]; else rd = {24'd0, led_m};
        4:  if (!we) rd = {24'd0, sw_m};
        8:  if (!we) rd = cyc;
        12: if (we) errcnt_m = 0; else rd = errcnt_m;
        default: ;
      endcase
    end
  endfunction

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic [31:0] cyc_snap);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_before_request", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    cyc_snap  = tb_cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata);
    logic [31:0] cyc, exp_rd;
    logic        err, exp_err;
    int          lat, exp_lat, exp_nwr, wr_before;
    wr_before = wren_cnt;
    do_req(we, addr, wdata, rdata, err, lat, cyc);
    predict(we, addr, wdata, cyc, exp_rd, exp_err, exp_lat, exp_nwr);
    check({tag, "_rdata"}, rdata, exp_rd);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_ram_writes"}, wren_cnt - wr_before, exp_nwr);
    check({tag, "_led"}, led, led_m);
  endtask

  initial begin
    logic [31:0] rd, hold_rd, addr;
    logic        we;
    int          wr_before, kind;

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; sw = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_ram_wren", ram_wren, 1'b0);
    check("rst_ram_addr", ram_addr, '0);
    check("rst_ram_data", ram_data, 32'd0);
    check("rst_led", led, 8'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 check("release_req_ready", req_ready, 1'b1);

    // RAM write then read of word 2
    wr_before = wren_cnt;
    run("ram_wr8", 1'b1, 32'h0000_0008, 32'h1234_5678, rd);
    check("ram_wr8_pulses", wren_cnt - wr_before, 1);
    check("ram_wr8_word", last_wr_addr, 6'd2);
    run("ram_rd8", 1'b0, 32'h0000_0008, 32'd0, rd);
    check("ram_rd8_value", rd, 32'h1234_5678);

    // LED write/read
    run("led_wr", 1'b1, MMIO_BASE, 32'hFFFF_FFA5, rd);
    check("led_value", led, 8'hA5);
    run("led_rd", 1'b0, MMIO_BASE, 32'd0, rd);
    check("led_rd_value", rd, 32'h0000_00A5);

    // Misaligned and unmapped reads, then ERRCNT
    wr_before = wren_cnt;
    run("misaligned_rd", 1'b0, 32'h0000_0006, 32'd0, rd);
    check("misaligned_pattern", rd, 32'hDEAD_BEEF);
    run("unmapped_rd", 1'b0, 32'h8000_0000, 32'd0, rd);
    check("unmapped_pattern", rd, 32'hDEAD_BEEF);
    check("err_no_ram_write", wren_cnt - wr_before, 0);
    run("errcnt_rd", 1'b0, MMIO_BASE + 32'hC, 32'd0, rd);
    check("errcnt_is_2", rd, 32'd2);

    // Response stall with a competing request held on the input
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = MMIO_BASE; req_wdata = '0;
    @(posedge clk);
    #1 req_we = 1'b1; req_wdata = 32'h0000_0077;
    @(negedge clk);
    hold_rd = resp_rdata;
    check("stall_first_rdata", hold_rd, {24'd0, led_m});
    for (int i = 0; i < 5; i++) begin
      check("stall_resp_valid", resp_valid, 1'b1);
      check("stall_rdata_stable", resp_rdata, hold_rd);
      check("stall_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("stall_resp_dropped", resp_valid, 1'b0);
    check("stall_led_untouched", led, led_m);

    // Switch synchronizer visibility
    sw = 8'h3C;
    repeat (3) @(posedge clk);
    sw_m = 8'h3C;
    run("sw_rd", 1'b0, MMIO_BASE + 32'h4, 32'd0, rd);
    check("sw_value", rd, 32'h0000_003C);
    run("sw_wr_ignored", 1'b1, MMIO_BASE + 32'h4, 32'hFFFF_FFFF, rd);

    // Randomized traffic across the whole map
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        sw = 8'($urandom);
        repeat (3) @(posedge clk);
        sw_m = sw;
      end
      kind = $urandom_range(0, 8);
      we   = 1'($urandom);
      case (kind)
        0, 1: addr = 32'($urandom_range(0, RAM_WORDS - 1)) * 4;
        2:    addr = 32'($urandom_range(0, RAM_WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
        3:    addr = MMIO_BASE;
        4:    addr = MMIO_BASE + 32'h4;
        5:    addr = MMIO_BASE + 32'h8;
        6:    begin addr = MMIO_BASE + 32'hC; we = ($urandom_range(0, 3) == 0); end
        7:    addr = 32'h0000_0100 + ($urandom & 32'h7FFF_FFFC);
        default: addr = MMIO_BASE + 32'($urandom_range(1, 3));
      endcase
      run("rand", we, addr, $urandom, rd);
    end

    // ERRCNT clear by write
    run("errcnt_clear", 1'b1, MMIO_BASE + 32'hC, 32'h1234_0000, rd);
    run("errcnt_after_clear", 1'b0, MMIO_BASE + 32'hC, 32'd0, rd);
    check("errcnt_zero", rd, 32'd0);

    // Reset during RAM_RD abandons the read
    run("pre_reset_wr", 1'b1, 32'h0000_0014, 32'hCAFE_F00D, rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0014;
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_midread_no_resp", resp_valid, 1'b0);
    end
    reset = 1'b1;
    led_m = 8'd0;
    errcnt_m = 0;
    @(posedge clk);
    #1 check("rst_midread_ready", req_ready, 1'b1);
    check("rst_midread_resp_valid", resp_valid, 1'b0);
    run("cycles_restart", 1'b0, MMIO_BASE + 32'h8, 32'd0, rd);
    check("cycles_restart_small", rd < 32'd16, 1'b1);
    run("ram_kept", 1'b0, 32'h0000_0014, 32'd0, rd);
    check("ram_kept_value", rd, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute backstop so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
